// File: rtl/dtree_pkg.sv
// Shared types and elaboration-time helpers for the multi-channel decision tree.
package dtree_pkg;

  typedef enum logic {S_IDLE, S_EVAL} state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Port/register width for an index range, never narrower than one bit
  function automatic int width_of(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  function automatic int acc_width(input int in_w, input int coeff_w, input int feats);
    return in_w + coeff_w + clog2(feats) + 1;
  endfunction

  function automatic int child_idx(input int node, input logic d);
    return 2 * node + 1 + (d ? 1 : 0);
  endfunction

  function automatic int sel_thr(input int feats);
    return feats;
  endfunction

  function automatic int sel_leaf(input int feats);
    return feats + 1;
  endfunction

endpackage

// File: rtl/dtree_node_eval.sv
// One tree node: signed dot product of a window against node coefficients,
// compared against the node threshold.
module dtree_node_eval #(
  parameter int FEATURES    = 3,
  parameter int IN_WIDTH    = 10,
  parameter int COEFF_WIDTH = 4,
  parameter int ACC_W       = 17
) (
  input  logic [FEATURES-1:0][IN_WIDTH-1:0]    feat,
  input  logic [FEATURES-1:0][COEFF_WIDTH-1:0] coeff,
  input  logic [ACC_W-1:0]                     thr,
  output logic                                 d
);

  logic signed [ACC_W-1:0] dot, fx, cx;

  always_comb begin
    dot = '0;
    fx  = '0;
    cx  = '0;
    for (int f = 0; f < FEATURES; f++) begin
      fx  = {{(ACC_W-IN_WIDTH){1'b0}}, feat[f]};
      cx  = {{(ACC_W-COEFF_WIDTH){coeff[f][COEFF_WIDTH-1]}}, coeff[f]};
      dot = dot + fx * cx;
    end
    d = (dot >= $signed(thr));
  end

endmodule

// File: rtl/dtree_mc.sv
// Multi-channel spike classifier: per-channel sample windows, runtime-loaded
// heap-ordered linear decision tree walked one node per cycle.
module dtree_mc
  import dtree_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int FEATURES    = 3,
  parameter int IN_WIDTH    = 10,
  parameter int COEFF_WIDTH = 4,
  parameter int DEPTH       = 2,
  localparam int NODES  = (1 << DEPTH) - 1,
  localparam int ACC_W  = acc_width(IN_WIDTH, COEFF_WIDTH, FEATURES),
  localparam int CH_W   = width_of(CHANNELS),
  localparam int NODE_W = width_of(NODES),
  localparam int SEL_W  = width_of(FEATURES + 2),
  localparam int LVL_W  = width_of(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IN_WIDTH-1:0] sample,
  input  logic [CH_W-1:0]   sample_ch,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              cfg_we,
  input  logic [NODE_W-1:0] cfg_node,
  input  logic [SEL_W-1:0]  cfg_sel,
  input  logic [ACC_W-1:0]  cfg_data,
  output logic [LVL_W-1:0]  level,
  output logic [DEPTH-1:0]  path,
  output logic [CH_W-1:0]   out_ch,
  output logic              out_valid
);

  localparam int FILL_W = width_of(FEATURES + 1);

  logic [CHANNELS-1:0][FEATURES-1:0][IN_WIDTH-1:0] win;
  logic [CHANNELS-1:0][FILL_W-1:0]                 fill;
  logic [NODES-1:0][FEATURES-1:0][COEFF_WIDTH-1:0] coeff;
  logic [NODES-1:0][ACC_W-1:0]                     thr;
  logic [NODES-1:0]                                leaf;

  state_e            state_q, state_d;
  logic [NODE_W-1:0] node_q;
  logic [LVL_W-1:0]  lvl_q, lvl_nxt;
  logic [DEPTH-1:0]  wpath_q, path_nxt;
  logic [CH_W-1:0]   ch_q;
  logic              accept, trig, dec, is_leaf, done;

  assign in_ready = (state_q == S_IDLE);
  assign accept   = in_valid && in_ready && (int'(sample_ch) < CHANNELS);
  // A window that is full, or becomes full with this sample, is classified
  assign trig     = accept && (fill[sample_ch] >= FILL_W'(FEATURES - 1));

  dtree_node_eval #(
    .FEATURES(FEATURES), .IN_WIDTH(IN_WIDTH), .COEFF_WIDTH(COEFF_WIDTH), .ACC_W(ACC_W)
  ) u_eval (
    .feat (win[ch_q]),
    .coeff(coeff[node_q]),
    .thr  (thr[node_q]),
    .d    (dec)
  );

  always_comb begin
    is_leaf  = leaf[node_q];
    lvl_nxt  = lvl_q + LVL_W'(1);
    done     = is_leaf || (lvl_nxt == LVL_W'(DEPTH));
    path_nxt = wpath_q;
    for (int k = 0; k < DEPTH; k++)
      if (lvl_q == LVL_W'(k)) path_nxt[k] = dec;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (trig) state_d = S_EVAL;
      S_EVAL:  if (done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      win       <= '0;
      fill      <= '0;
      coeff     <= '0;
      thr       <= '0;
      leaf      <= '0;
      node_q    <= '0;
      lvl_q     <= '0;
      wpath_q   <= '0;
      ch_q      <= '0;
      level     <= '0;
      path      <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (accept) begin
        win[sample_ch][0] <= sample;
        for (int f = 1; f < FEATURES; f++) win[sample_ch][f] <= win[sample_ch][f-1];
        if (fill[sample_ch] != FILL_W'(FEATURES)) fill[sample_ch] <= fill[sample_ch] + FILL_W'(1);
      end
      if (trig) begin
        node_q  <= '0;
        lvl_q   <= '0;
        wpath_q <= '0;
        ch_q    <= sample_ch;
      end
      if (state_q == S_EVAL) begin
        if (done) begin
          out_valid <= 1'b1;
          out_ch    <= ch_q;
          level     <= is_leaf ? lvl_q : lvl_nxt;
          path      <= is_leaf ? wpath_q : path_nxt;
        end else begin
          node_q  <= NODE_W'(child_idx(int'(node_q), dec));
          lvl_q   <= lvl_nxt;
          wpath_q <= path_nxt;
        end
      end
      // Config writes land after this cycle's node read, so readers see the old value
      if (cfg_we && int'(cfg_node) < NODES) begin
        for (int f = 0; f < FEATURES; f++)
          if (int'(cfg_sel) == f) coeff[cfg_node][f] <= cfg_data[COEFF_WIDTH-1:0];
        if (int'(cfg_sel) == sel_thr(FEATURES))  thr[cfg_node]  <= cfg_data;
        if (int'(cfg_sel) == sel_leaf(FEATURES)) leaf[cfg_node] <= cfg_data[0];
      end
    end
  end

endmodule
